// File: rtl/nes_frame_reader_if.sv
// Pad-side and result-side signals of the NES controller reader.
// The reader itself is the master; the pad, the external state counter and the consumer form the slave side.
interface nes_frame_reader_if;
    logic       nes_data;
    logic [2:0] bit_idx;
    logic       nes_latch;
    logic       nes_pulse;
    logic       seq_clk;
    logic       seq_rst;
    logic [7:0] buttons;
    logic       valid;
    logic       seq_err;

    modport master (
        input  nes_data, bit_idx,
        output nes_latch, nes_pulse, seq_clk, seq_rst, buttons, valid, seq_err
    );

    modport slave (
        output nes_data, bit_idx,
        input  nes_latch, nes_pulse, seq_clk, seq_rst, buttons, valid, seq_err
    );
endinterface

// File: rtl/nes_frame_reader.sv
// Polls one NES pad: latch, seven shift pulses, eight captured bits cross-checked against the
// external 3-bit state counter, then a parallel button byte with a one-cycle valid strobe.
module nes_frame_reader #(
    parameter int HALF_PERIOD = 300,
    parameter int FRAME_GAP   = 833000
) (
    input  logic                clk,
    input  logic                reset,
    nes_frame_reader_if.master  bus
);
    localparam int GAP_W  = $clog2(FRAME_GAP + 1);
    localparam int HALF_W = $clog2(HALF_PERIOD + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LATCH = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
    logic              phase_q, phase_d;
    logic [2:0]        exp_idx_q, exp_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic [1:0]        sync_q, sync_d;
    logic              latch_q, latch_d;
    logic              pulse_q, pulse_d;
    logic              seq_clk_q, seq_clk_d;
    logic              seq_rst_q, seq_rst_d;
    logic [7:0]        buttons_q, buttons_d;
    logic              valid_q, valid_d;
    logic              seq_err_q, seq_err_d;

    logic tick;
    logic data_s;

    assign tick   = (half_cnt_q == HALF_W'(HALF_PERIOD - 1));
    assign data_s = sync_q[1];
    assign sync_d = {sync_q[0], bus.nes_data};

    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        half_cnt_d = half_cnt_q;
        phase_d    = phase_q;
        exp_idx_d  = exp_idx_q;
        shift_d    = shift_q;
        buttons_d  = buttons_q;
        valid_d    = 1'b0;
        seq_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                half_cnt_d = '0;
                phase_d    = 1'b0;
                if (gap_cnt_q == GAP_W'(FRAME_GAP - 1)) begin
                    gap_cnt_d = '0;
                    state_d   = ST_LATCH;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            ST_LATCH: begin
                half_cnt_d = tick ? '0 : half_cnt_q + 1'b1;
                if (tick) begin
                    phase_d = ~phase_q;
                    // Bit 0 (A) is already on the data line while latch is held.
                    if (phase_q) begin
                        shift_d[0] = ~data_s;
                        exp_idx_d  = 3'd1;
                        state_d    = ST_READ;
                    end
                end
            end
            ST_READ: begin
                half_cnt_d = tick ? '0 : half_cnt_q + 1'b1;
                if (tick) begin
                    phase_d = ~phase_q;
                    // End of the low phase: the counter must agree with the bit we expect.
                    if (phase_q) begin
                        if (bus.bit_idx == exp_idx_q) begin
                            shift_d[exp_idx_q] = ~data_s;
                            if (exp_idx_q == 3'd7) begin
                                state_d = ST_DONE;
                            end else begin
                                exp_idx_d = exp_idx_q + 3'd1;
                            end
                        end else begin
                            seq_err_d = 1'b1;
                            gap_cnt_d = '0;
                            state_d   = ST_IDLE;
                        end
                    end
                end
            end
            ST_DONE: begin
                buttons_d = shift_q;
                valid_d   = 1'b1;
                gap_cnt_d = '0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pin outputs follow the next state so they line up with the state register.
        latch_d   = (state_d == ST_LATCH);
        pulse_d   = (state_d == ST_READ) && !phase_d;
        seq_clk_d = pulse_d;
        seq_rst_d = (state_d != ST_READ);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            gap_cnt_q  <= '0;
            half_cnt_q <= '0;
            phase_q    <= 1'b0;
            exp_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            sync_q     <= 2'b00;
            latch_q    <= 1'b0;
            pulse_q    <= 1'b0;
            seq_clk_q  <= 1'b0;
            seq_rst_q  <= 1'b1;
            buttons_q  <= 8'h00;
            valid_q    <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            half_cnt_q <= half_cnt_d;
            phase_q    <= phase_d;
            exp_idx_q  <= exp_idx_d;
            shift_q    <= shift_d;
            sync_q     <= sync_d;
            latch_q    <= latch_d;
            pulse_q    <= pulse_d;
            seq_clk_q  <= seq_clk_d;
            seq_rst_q  <= seq_rst_d;
            buttons_q  <= buttons_d;
            valid_q    <= valid_d;
            seq_err_q  <= seq_err_d;
        end
    end

    assign bus.nes_latch = latch_q;
    assign bus.nes_pulse = pulse_q;
    assign bus.seq_clk   = seq_clk_q;
    assign bus.seq_rst   = seq_rst_q;
    assign bus.buttons   = buttons_q;
    assign bus.valid     = valid_q;
    assign bus.seq_err   = seq_err_q;
endmodule

// File: tb/tb_nes_frame_reader.sv
// Bench for nes_frame_reader: a pad model and a 3-bit state counter surround the reader;
// frame timing and captured bytes are compared against values derived from the pad contents.
module tb_nes_frame_reader;
    localparam int H     = 4;
    localparam int G     = 20;
    localparam int FRAME = G + 16 * H + 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    nes_frame_reader_if bus ();

    nes_frame_reader #(.HALF_PERIOD(H), .FRAME_GAP(G)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pad and counter environment
    logic [7:0] pressed    = 8'h00;
    logic       pad_absent = 1'b0;
    logic       stuck      = 1'b0;
    logic       glitch_en  = 1'b0;
    logic       glitch     = 1'b0;
    logic [3:0] pad_idx    = 4'd8;
    logic       pad_pulse_prev = 1'b0;
    logic [2:0] ctr        = 3'd0;
    logic       ctr_clk_prev = 1'b0;
    logic       latch_prev = 1'b0;
    int         cyc        = 0;
    int         latch_cyc  = -1000;
    logic       pad_bit;

    always @(posedge clk) cyc <= cyc + 1;

    // Pad shifts and counter counts on the rise of latch/pulse, seen on the falling clk edge.
    always @(negedge clk) begin
        if (bus.nes_latch) pad_idx <= 4'd0;
        else if (bus.nes_pulse && !pad_pulse_prev && pad_idx < 4'd8) pad_idx <= pad_idx + 4'd1;
        pad_pulse_prev <= bus.nes_pulse;
        if (bus.seq_rst) ctr <= 3'd0;
        else if (bus.seq_clk && !ctr_clk_prev) ctr <= ctr + 3'd1;
        ctr_clk_prev <= bus.seq_clk;
        if (bus.nes_latch && !latch_prev) latch_cyc <= cyc;
        latch_prev <= bus.nes_latch;
        // Invert the line for the half cycle just before each sample edge.
        glitch <= glitch_en && ((cyc - latch_cyc) < 16 * H) && (((cyc - latch_cyc) % (2 * H)) == 2 * H - 1);
    end

    always_comb begin
        pad_bit = 1'b0;
        if (pad_idx < 4'd8) pad_bit = ~pressed[pad_idx[2:0]];
    end

    assign bus.nes_data = pad_absent ? 1'b1 : (pad_bit ^ glitch);
    assign bus.bit_idx  = (stuck && ctr > 3'd3) ? 3'd3 : ctr;

    // Observation results of one frame
    int         obs_latch_at, obs_latch_len, obs_pulses, obs_first_pulse;
    int         obs_hi_bad, obs_gap_bad, obs_sclk_diff, obs_rst_low, obs_both;
    int         obs_valid_at, obs_err_at;
    logic [7:0] obs_buttons;
    logic [7:0] model_buttons = 8'h00;

    task automatic observe(input string name, input int budget);
        int n, hi_run, last_rise;
        logic lp, pp;
        obs_latch_at = -1; obs_latch_len = 0; obs_pulses = 0; obs_first_pulse = -1;
        obs_hi_bad = 0; obs_gap_bad = 0; obs_sclk_diff = 0; obs_rst_low = 0; obs_both = 0;
        obs_valid_at = -1; obs_err_at = -1; obs_buttons = bus.buttons;
        lp = bus.nes_latch; pp = bus.nes_pulse; hi_run = 0; last_rise = -1; n = 0;
        while (n < budget) begin
            @(posedge clk); #1; n++;
            if (bus.nes_latch) begin
                obs_latch_len++;
                if (!lp && obs_latch_at < 0) obs_latch_at = n;
            end
            if (bus.nes_pulse) begin
                if (!pp) begin
                    obs_pulses++;
                    if (last_rise < 0) obs_first_pulse = n;
                    else if (n - last_rise != 2 * H) obs_gap_bad++;
                    last_rise = n;
                    hi_run = 0;
                end
                hi_run++;
            end else if (pp && hi_run != H) begin
                obs_hi_bad++;
            end
            if (bus.seq_clk !== bus.nes_pulse) obs_sclk_diff++;
            if (!bus.seq_rst) obs_rst_low++;
            if (bus.valid && bus.seq_err) obs_both++;
            lp = bus.nes_latch; pp = bus.nes_pulse;
            if (bus.valid) begin obs_valid_at = n; obs_buttons = bus.buttons; break; end
            if (bus.seq_err) begin obs_err_at = n; obs_buttons = bus.buttons; break; end
        end
        $display("frame %s: latch_at=%0d pulses=%0d valid_at=%0d err_at=%0d buttons=%02h",
                 name, obs_latch_at, obs_pulses, obs_valid_at, obs_err_at, obs_buttons);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.nes_latch !== 1'b0 || bus.nes_pulse !== 1'b0 || bus.seq_clk !== 1'b0) begin errors++; $display("FAIL reset_pins: got latch=%b pulse=%b seq_clk=%b expected 000", bus.nes_latch, bus.nes_pulse, bus.seq_clk); end
        checks++; if (bus.seq_rst !== 1'b1) begin errors++; $display("FAIL reset_seq_rst: got %b expected 1", bus.seq_rst); end
        checks++; if (bus.buttons !== 8'h00 || bus.valid !== 1'b0 || bus.seq_err !== 1'b0) begin errors++; $display("FAIL reset_outputs: got buttons=%02h valid=%b seq_err=%b expected 00/0/0", bus.buttons, bus.valid, bus.seq_err); end
        pressed = 8'h00;
        reset = 1'b0;
        observe("idle", 200);
        checks++; if (obs_latch_at !== G) begin errors++; $display("FAIL idle_latch_at: got %0d expected %0d", obs_latch_at, G); end
        checks++; if (obs_latch_len !== 2 * H) begin errors++; $display("FAIL idle_latch_len: got %0d expected %0d", obs_latch_len, 2 * H); end
        checks++; if (obs_pulses !== 7) begin errors++; $display("FAIL idle_pulse_count: got %0d expected 7", obs_pulses); end
        checks++; if (obs_first_pulse !== G + 2 * H) begin errors++; $display("FAIL idle_first_pulse: got %0d expected %0d", obs_first_pulse, G + 2 * H); end
        checks++; if (obs_hi_bad !== 0 || obs_gap_bad !== 0) begin errors++; $display("FAIL idle_pulse_shape: got hi_bad=%0d gap_bad=%0d expected 0/0", obs_hi_bad, obs_gap_bad); end
        checks++; if (obs_sclk_diff !== 0) begin errors++; $display("FAIL idle_seq_clk: got %0d differing cycles expected 0", obs_sclk_diff); end
        checks++; if (obs_rst_low !== 14 * H) begin errors++; $display("FAIL idle_seq_rst_low: got %0d expected %0d", obs_rst_low, 14 * H); end
        checks++; if (obs_valid_at !== FRAME) begin errors++; $display("FAIL idle_valid_at: got %0d expected %0d", obs_valid_at, FRAME); end
        model_buttons = 8'h00;
        checks++; if (obs_buttons !== model_buttons) begin errors++; $display("FAIL idle_buttons: got %02h expected %02h", obs_buttons, model_buttons); end
    endtask

    task automatic test_pattern;
        logic [7:0] v;
        for (int i = 0; i < 5; i++) begin
            v = (i == 0) ? 8'h5A : 8'($urandom);
            pressed = v;
            observe("pattern", 200);
            model_buttons = v;
            checks++; if (obs_valid_at !== FRAME) begin errors++; $display("FAIL pattern_valid_at: got %0d expected %0d", obs_valid_at, FRAME); end
            checks++; if (obs_buttons !== model_buttons) begin errors++; $display("FAIL pattern_buttons: got %02h expected %02h", obs_buttons, model_buttons); end
        end
        @(posedge clk); #1;
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL valid_width: got %b expected 0", bus.valid); end
        checks++; if (bus.buttons !== model_buttons) begin errors++; $display("FAIL buttons_hold: got %02h expected %02h", bus.buttons, model_buttons); end
        pressed = 8'h00;
        observe("realign", 200);
        model_buttons = 8'h00;
        checks++; if (obs_valid_at !== FRAME - 1 || obs_buttons !== model_buttons) begin errors++; $display("FAIL realign: got at=%0d buttons=%02h expected at=%0d buttons=%02h", obs_valid_at, obs_buttons, FRAME - 1, model_buttons); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] seq [3];
        seq[0] = 8'hFF; seq[1] = 8'h00; seq[2] = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            pad_absent = (i == 3);
            if (i < 3) pressed = seq[i];
            observe(pad_absent ? "absent" : "b2b", 200);
            model_buttons = pad_absent ? 8'h00 : pressed;
            checks++; if (obs_valid_at !== FRAME || obs_err_at !== -1) begin errors++; $display("FAIL b2b_period: got valid_at=%0d err_at=%0d expected %0d/-1", obs_valid_at, obs_err_at, FRAME); end
            checks++; if (obs_buttons !== model_buttons) begin errors++; $display("FAIL b2b_buttons: got %02h expected %02h", obs_buttons, model_buttons); end
        end
        pad_absent = 1'b0;
    endtask

    task automatic test_seq_error;
        logic [7:0] v;
        v = 8'h3C;
        pressed = v;
        observe("prime", 200);
        model_buttons = v;
        stuck = 1'b1;
        pressed = ~v;
        observe("stuck", 200);
        checks++; if (obs_err_at !== G + 2 * H + 4 * 2 * H) begin errors++; $display("FAIL stuck_err_at: got %0d expected %0d", obs_err_at, G + 10 * H); end
        checks++; if (obs_valid_at !== -1 || obs_both !== 0) begin errors++; $display("FAIL stuck_no_valid: got valid_at=%0d both=%0d expected -1/0", obs_valid_at, obs_both); end
        checks++; if (obs_buttons !== model_buttons) begin errors++; $display("FAIL stuck_buttons: got %02h expected %02h", obs_buttons, model_buttons); end
        stuck = 1'b0;
        v = 8'($urandom);
        pressed = v;
        observe("recover", 200);
        model_buttons = v;
        checks++; if (obs_latch_at !== G || obs_valid_at !== FRAME) begin errors++; $display("FAIL recover_timing: got latch=%0d valid=%0d expected %0d/%0d", obs_latch_at, obs_valid_at, G, FRAME); end
        checks++; if (obs_buttons !== model_buttons) begin errors++; $display("FAIL recover_buttons: got %02h expected %02h", obs_buttons, model_buttons); end
    endtask

    task automatic test_reset_mid_read;
        logic [7:0] v;
        v = 8'($urandom);
        pressed = v;
        // Start of bit 5's read period plus two cycles, pulse still high.
        repeat (G + 2 * H + 4 * 2 * H + 2) @(posedge clk);
        #3; reset = 1'b1;
        #1;
        model_buttons = 8'h00;
        checks++; if (bus.nes_latch !== 1'b0 || bus.nes_pulse !== 1'b0 || bus.seq_clk !== 1'b0 || bus.seq_rst !== 1'b1) begin errors++; $display("FAIL midreset_pins: got latch=%b pulse=%b seq_clk=%b seq_rst=%b expected 0001", bus.nes_latch, bus.nes_pulse, bus.seq_clk, bus.seq_rst); end
        checks++; if (bus.valid !== 1'b0 || bus.buttons !== model_buttons) begin errors++; $display("FAIL midreset_outputs: got valid=%b buttons=%02h expected 0/%02h", bus.valid, bus.buttons, model_buttons); end
        repeat (2) @(posedge clk);
        #1; reset = 1'b0;
        observe("after_reset", 200);
        model_buttons = v;
        checks++; if (obs_latch_at !== G) begin errors++; $display("FAIL midreset_latch_at: got %0d expected %0d", obs_latch_at, G); end
        checks++; if (obs_valid_at !== FRAME || obs_buttons !== model_buttons) begin errors++; $display("FAIL midreset_frame: got at=%0d buttons=%02h expected at=%0d buttons=%02h", obs_valid_at, obs_buttons, FRAME, model_buttons); end
    endtask

    task automatic test_sync_latency;
        logic [7:0] v;
        glitch_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            v = (i == 0) ? 8'hC3 : 8'($urandom);
            pressed = v;
            observe("glitch", 200);
            model_buttons = v;
            checks++; if (obs_valid_at !== FRAME || obs_buttons !== model_buttons) begin errors++; $display("FAIL sync_latency: got at=%0d buttons=%02h expected at=%0d buttons=%02h", obs_valid_at, obs_buttons, FRAME, model_buttons); end
        end
        glitch_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_back_to_back();
        test_seq_error();
        test_reset_mid_read();
        test_sync_latency();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
